// File: rtl/bit_serializer.sv
// Parallel-to-serial stage feeding the serial "1011" detector.
// Emits one bit per clk with zero-gap back-to-back words and a fixed idle bit otherwise.
module bit_serializer #(
    parameter int       WIDTH     = 8,
    parameter bit       MSB_FIRST = 1'b1,
    parameter bit       IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last
);

    localparam int CNT_W = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  shreg;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_last;
    logic              head_bit;

    assign cnt_last = (cnt == LAST_IDX);
    assign head_bit = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

    // Outputs are decoded from registers only, so reset reaches them without waiting for clk.
    assign din_ready  = (state == IDLE) || cnt_last;
    assign sout       = (state == SHIFT) ? head_bit : IDLE_BIT;
    assign sout_valid = (state == SHIFT);
    assign sout_last  = (state == SHIFT) && cnt_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (din_valid) begin
                        shreg <= din;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_last) begin
                        cnt <= '0;
                        if (din_valid) begin
                            shreg <= din;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        // Zero fill shifts in behind the head; it is never presented.
                        if (MSB_FIRST) begin
                            shreg <= {shreg[WIDTH-2:0], 1'b0};
                        end else begin
                            shreg <= {1'b0, shreg[WIDTH-1:1]};
                        end
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial stage that feeds the serial "1011" sequence detector.
- Accepts WIDTH-bit words from a valid/ready source and emits one bit per clk on sout, with no gaps between back-to-back words.
- When idle, drives a fixed idle bit so the detector, which samples every cycle, sees a defined stream.
- Provides sout_valid and sout_last so downstream logic can qualify detector matches per word.

Parameters:
- WIDTH, 8, word width in bits; must be >= 2.
- MSB_FIRST, 1, 1 = transmit din[WIDTH-1] first; 0 = transmit din[0] first.
- IDLE_BIT, 0, value driven on sout when no word is in flight.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset; forces idle state immediately.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din holds a word to transfer.
- din_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial bit stream (detector x input).
- sout_valid  output  1  sout carries a data bit (not idle fill).
- sout_last  output  1  sout carries the final bit of the current word.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values:
  - state = IDLE; shift register = 0; bit counter = 0.
  - sout = IDLE_BIT, sout_valid = 0, sout_last = 0, din_ready = 1.
  - All outputs take these values immediately on reset assertion, not at the next edge.
- State machine has two states, IDLE and SHIFT.
  - IDLE: sout = IDLE_BIT, sout_valid = 0, din_ready = 1.
    - Transfer occurs at a posedge where din_valid=1 and din_ready=1: load din into the shift register, counter = 0, go to SHIFT.
  - SHIFT: sout = current head bit of the shift register (bit WIDTH-1 if MSB_FIRST, else bit 0); sout_valid = 1.
    - sout_last = 1 when counter == WIDTH-1.
    - Each posedge with counter < WIDTH-1: shift by one toward the head and increment the counter.
    - At a posedge with counter == WIDTH-1:
      - If din_valid=1: load the new din, counter = 0, stay in SHIFT (zero-gap back-to-back).
      - Otherwise: go to IDLE.
- din_ready = (state == IDLE) or (state == SHIFT and counter == WIDTH-1). It is a function of registered state only; there is no combinational path from din_valid.
- sout, sout_valid and sout_last depend on registered state only. There are no combinational paths from inputs to them.
- Latency: a word accepted at edge N drives its first bit during cycle N+1 (between edges N and N+1) and its last bit during cycle N+WIDTH. Exactly WIDTH valid bits per word.
- Throughput: one bit per clk sustained; a continuous din_valid stream produces an unbroken sout_valid.
- din_valid while din_ready=0: ignored, no capture. Upstream must hold din stable until the transfer.
- din changes while not transferring: no effect on shift-register contents.
- Counter width: clog2(WIDTH), with a minimum of 1 bit. The counter never exceeds WIDTH-1.
- Reset mid-word: the in-flight word is discarded with no partial completion. The first word after reset release starts from bit 0.
- Shifted-in fill bits are 0 and are never presented, because sout_valid drops or a new load occurs first.

Test Plan:
1. MSB-first load: reset, then din=8'hB0 with din_valid for one cycle -> sout = 1,0,1,1,0,0,0,0 on 8 consecutive cycles; sout_valid high exactly 8 cycles; sout_last high only on the 8th; the downstream detector fires z=1 in the cycle sout carries bit 4.
2. Back-to-back: din_valid held with 8'hA5 then 8'h3C -> 16 contiguous valid bits 1010_0101_0011_1100; din_ready=1 only in idle and last-bit cycles; no idle-bit gap between words.
3. Busy ignore: while the first word is at bit 2, pulse din_valid with 8'hFF -> din_ready=0, word not captured, original word completes unchanged, then return to IDLE.
4. LSB-first: MSB_FIRST=0, din=8'h0D -> sout = 1,0,1,1,0,0,0,0.
5. Async reset mid-word: assert reset between edges at bit 3 -> sout=IDLE_BIT, sout_valid=0, din_ready=1 immediately; next word 8'hB0 serializes fully from bit 0.
6. Idle stream: no din_valid for 20 cycles -> sout constant IDLE_BIT, sout_valid=0, detector z stays 0.
